// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine step sequencer (wash, rinse, dry) with pause and lid interlock.
// Optional DONE_BEEP_EN macro adds a completion beep lasting BEEP_T ticks.
module wash_sequencer #(
  parameter int FILL_UNIT = 2,
  parameter int WASH_T    = 10,
  parameter int RINSE_T   = 6,
  parameter int DRAIN_T   = 3,
  parameter int SPIN_T    = 4,
  parameter int BEEP_T    = 5
) (
  input  logic       clk,
  input  logic       in_resetBtn,
  input  logic       in_tick,
  input  logic       in_runBtn,
  input  logic       in_openBtn,
  input  logic [2:0] in_mode,
  input  logic [1:0] in_water,
  output logic       out_inValve,
  output logic       out_outValve,
  output logic       out_motor,
  output logic       out_spin,
  output logic [3:0] out_state,
  output logic [7:0] out_remain,
  output logic       out_paused,
  output logic       out_done,
  output logic       out_beep
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, W_FILL = 4'd1, W_AGIT = 4'd2, W_DRAIN = 4'd3, R_FILL = 4'd4, R_AGIT = 4'd5,
    R_DRAIN = 4'd6, R_SPIN = 4'd7, D_DRAIN = 4'd8, D_SPIN = 4'd9, DONE = 4'd10
  } state_t;
  state_t state, nextStep, firstStep;
  logic prevRun, runEdge, runStep, countTick, active, doneEntry;
  logic [1:0] modeLat, waterLat;
  function automatic logic [7:0] stepLen(input state_t s, input logic [1:0] lvl);
    case (s)
      W_FILL, R_FILL:           return 8'(FILL_UNIT * (int'(lvl) + 1));
      W_AGIT:                   return 8'(WASH_T);
      R_AGIT:                   return 8'(RINSE_T);
      W_DRAIN, R_DRAIN, D_DRAIN: return 8'(DRAIN_T);
      R_SPIN, D_SPIN:           return 8'(SPIN_T);
      default:                  return 8'd0;
    endcase
  endfunction
  assign runEdge   = in_runBtn & ~prevRun;
  assign runStep   = (state >= W_FILL) && (state <= D_SPIN);
  assign countTick = in_tick & runStep & ~out_paused & ~in_openBtn;
  assign doneEntry = countTick && (out_remain == 8'd1) && (nextStep == DONE);
  assign firstStep = in_mode[2] ? W_FILL : in_mode[1] ? R_FILL : in_mode[0] ? D_DRAIN : IDLE;
  always_comb begin
    nextStep = DONE;
    case (state)
      W_FILL:  nextStep = W_AGIT;
      W_AGIT:  nextStep = W_DRAIN;
      W_DRAIN: nextStep = modeLat[1] ? R_FILL : modeLat[0] ? D_DRAIN : DONE;
      R_FILL:  nextStep = R_AGIT;
      R_AGIT:  nextStep = R_DRAIN;
      R_DRAIN: nextStep = R_SPIN;
      R_SPIN:  nextStep = modeLat[0] ? D_DRAIN : DONE;
      D_DRAIN: nextStep = D_SPIN;
      default: nextStep = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge in_resetBtn) begin
    if (!in_resetBtn) begin
      state      <= IDLE;
      out_remain <= 8'd0;
      out_paused <= 1'b0;
      prevRun    <= 1'b0;
      modeLat    <= 2'd0;
      waterLat   <= 2'd0;
    end else begin
      prevRun <= in_runBtn;
      case (state)
        IDLE: begin
          out_paused <= 1'b0;
          out_remain <= 8'd0;
          if (runEdge && in_mode != 3'd0 && !in_openBtn) begin
            modeLat    <= in_mode[1:0];
            waterLat   <= in_water;
            state      <= firstStep;
            out_remain <= stepLen(firstStep, in_water);
          end
        end
        W_FILL, W_AGIT, W_DRAIN, R_FILL, R_AGIT, R_DRAIN, R_SPIN, D_DRAIN, D_SPIN: begin
          if (runEdge) out_paused <= ~out_paused;
          if (countTick) begin
            if (out_remain > 8'd1) out_remain <= out_remain - 8'd1;
            else begin
              state      <= nextStep;
              out_remain <= stepLen(nextStep, waterLat);
              if (nextStep == DONE) out_paused <= 1'b0;
            end
          end
        end
        DONE: begin
          out_paused <= 1'b0;
          out_remain <= 8'd0;
          if (runEdge) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          out_remain <= 8'd0;
          out_paused <= 1'b0;
        end
      endcase
    end
  end
  assign active       = runStep & ~out_paused & ~in_openBtn;
  assign out_inValve  = active & (state == W_FILL || state == R_FILL);
  assign out_motor    = active & (state == W_AGIT || state == R_AGIT || state == R_SPIN || state == D_SPIN);
  assign out_outValve = active & (state == W_DRAIN || state == R_DRAIN || state == D_DRAIN ||
                                  state == R_SPIN || state == D_SPIN);
  assign out_spin     = active & (state == R_SPIN || state == D_SPIN);
  assign out_state    = state;
  assign out_done     = (state == DONE);
`ifdef DONE_BEEP_EN
  logic [7:0] beepCnt;
  // beep ticks are counted even with the lid open
  always_ff @(posedge clk or negedge in_resetBtn) begin
    if (!in_resetBtn) begin
      out_beep <= 1'b0;
      beepCnt  <= 8'd0;
    end else if (runEdge) begin
      out_beep <= 1'b0;
      beepCnt  <= 8'd0;
    end else if (doneEntry) begin
      out_beep <= 1'b1;
      beepCnt  <= 8'(BEEP_T);
    end else if (out_beep && in_tick) begin
      out_beep <= (beepCnt > 8'd1);
      beepCnt  <= beepCnt - 8'd1;
    end
  end
`else
  assign out_beep = 1'b0;
`endif
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed checks of wash_sequencer with default parameters.
module tb_wash_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, tck = 1'b0, run = 1'b0, lid = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [1:0] water = 2'd0;
  logic inV, outV, motor, spin, paused, done, beep;
  logic [3:0] st;
  logic [7:0] remain;
  int tests = 0, failed = 0;

  wash_sequencer dut (
    .clk(clk), .in_resetBtn(rst_n), .in_tick(tck), .in_runBtn(run), .in_openBtn(lid),
    .in_mode(mode), .in_water(water), .out_inValve(inV), .out_outValve(outV),
    .out_motor(motor), .out_spin(spin), .out_state(st), .out_remain(remain),
    .out_paused(paused), .out_done(done), .out_beep(beep)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tck = 1'b1; cyc();
      tck = 1'b0; cyc();
    end
  endtask

  task automatic press();
    run = 1'b1; cyc();
    run = 1'b0; cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chkAct(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, inV, outV, motor, spin}, {28'd0, exp});
  endtask

  initial begin
    #12;
    chk("rst_state", st, 0); chk("rst_remain", remain, 0); chkAct("rst_act", 4'b0000);
    chk("rst_flags", {paused, done, beep}, 0);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("idle_hold", st, 0);
    // wash only, water 0
    mode = 3'b100; water = 2'd0; press();
    chk("w_fill", st, 1); chk("w_fill_rem", remain, 2); chkAct("w_fill_act", 4'b1000);
    tick(2);
    chk("w_agit", st, 2); chk("w_agit_rem", remain, 10); chkAct("w_agit_act", 4'b0010);
    tick(10);
    chk("w_drain", st, 3); chk("w_drain_rem", remain, 3); chkAct("w_drain_act", 4'b0100);
    tick(3);
    chk("w_done", st, 10); chk("w_done_flag", done, 1); chk("w_done_rem", remain, 0);
    chkAct("w_done_act", 4'b0000);
`ifdef DONE_BEEP_EN
    chk("beep_on", beep, 1);
    tick(4); chk("beep_4", beep, 1);
    tick(1); chk("beep_off", beep, 0);
`else
    chk("beep_off", beep, 0);
    tick(6); chk("beep_stay", beep, 0);
`endif
    press();
    chk("done_to_idle", st, 0); chk("idle_done", done, 0);
    // dry only
    mode = 3'b001; press();
    chk("d_drain", st, 8); chk("d_drain_rem", remain, 3); chkAct("d_drain_act", 4'b0100);
    tick(3);
    chk("d_spin", st, 9); chk("d_spin_rem", remain, 4); chkAct("d_spin_act", 4'b0111);
    tick(4);
    chk("d_done", st, 10);
    press();
    // wash+rinse, water 3, lid freeze, mode change ignored
    mode = 3'b110; water = 2'd3; press();
    chk("wr_fill_rem", remain, 8);
    mode = 3'b001; water = 2'd0;
    tick(11);
    chk("wr_agit", st, 2); chk("wr_agit_rem", remain, 7);
    lid = 1'b1; tick(5);
    chk("lid_state", st, 2); chk("lid_rem", remain, 7); chkAct("lid_act", 4'b0000);
    chk("lid_paused", paused, 0);
    lid = 1'b0; cyc();
    chkAct("lid_close", 4'b0010);
    tick(10);
    chk("r_fill", st, 4); chk("r_fill_rem", remain, 8);
    tick(20);
    chk("r_spin_last", st, 7); chk("r_spin_rem", remain, 1);
    tick(1);
    chk("wr_done", st, 10);
    press();
    // rejected starts
    mode = 3'b000; press(); chk("mode0_idle", st, 0);
    mode = 3'b100; lid = 1'b1; press(); chk("lid_idle", st, 0);
    lid = 1'b0;
    // pause in rinse
    mode = 3'b010; water = 2'd0; press();
    chk("r_only_fill", st, 4); chk("r_only_rem", remain, 2);
    tick(2);
    chk("r_agit", st, 5);
    press();
    chk("paused", paused, 1); chkAct("paused_act", 4'b0000);
    tick(4);
    chk("paused_state", st, 5); chk("paused_rem", remain, 6);
    press();
    chk("resumed", paused, 0); chkAct("resumed_act", 4'b0010);
    tick(9);
    chk("r_spin", st, 7); chk("r_spin_rem4", remain, 4);
    tick(2);
    chkAct("r_spin_act", 4'b0111);
    // async reset mid-spin
    #2 rst_n = 1'b0; #1;
    chk("arst_state", st, 0); chk("arst_remain", remain, 0); chkAct("arst_act", 4'b0000);
    chk("arst_flags", {paused, done, beep}, 0);
    cyc(); rst_n = 1'b1; cyc();
    tick(2);
    chk("post_rst_idle", st, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have parameter FILL_UNIT, default 2, fill ticks per water level step (fill time = FILL_UNIT*(in_water+1)).
REQ-002 SHALL have parameters WASH_T 10, RINSE_T 6, DRAIN_T 3, SPIN_T 4, BEEP_T 5, all step lengths in ticks, each >=1.
REQ-003 SHALL have ports: clk  in  1  system clock (all state on rising edge).
REQ-004 in_resetBtn  in  1  asynchronous active-low reset.
REQ-005 in_tick  in  1  one-cycle pulse at 1 Hz time base.
REQ-006 in_runBtn  in  1  level; rising edge = start / pause-resume / acknowledge.
REQ-007 in_openBtn  in  1  lid open level; 1 = open.
REQ-008 in_mode  in  3  phase enables: [2] wash, [1] rinse, [0] dry.
REQ-009 in_water  in  2  water level 0..3.
REQ-010 out_inValve, out_outValve, out_motor, out_spin  out  1 each  actuator commands.
REQ-011 out_state  out  4  current step code; out_remain  out  8  ticks left in step.
REQ-012 out_paused  out  1; out_done  out  1; out_beep  out  1.

Function
REQ-013 States/codes: IDLE 0, W_FILL 1, W_AGIT 2, W_DRAIN 3, R_FILL 4, R_AGIT 5, R_DRAIN 6, R_SPIN 7, D_DRAIN 8, D_SPIN 9, DONE 10; codes 11-15 unreachable, recover to IDLE.
REQ-014 Run edge = in_runBtn & ~prev, prev registered each cycle.
REQ-015 IDLE: run edge with in_mode!=0 and in_openBtn=0 latches in_mode and in_water, enters first enabled phase (W_FILL, else R_FILL, else D_DRAIN), unpaused; otherwise stays IDLE.
REQ-016 Entering a step loads out_remain with its length: FILL steps FILL_UNIT*(level+1), AGIT WASH_T/RINSE_T, DRAIN DRAIN_T, SPIN SPIN_T.
REQ-017 Tick counted only when state is a run step, out_paused=0 and in_openBtn=0; counted tick with out_remain>1 decrements; with out_remain==1 advances to next step on the next clock.
REQ-018 Order: W_FILL->W_AGIT->W_DRAIN->(R_FILL if rinse, else D_DRAIN if dry, else DONE); R_FILL->R_AGIT->R_DRAIN->R_SPIN->(D_DRAIN if dry, else DONE); D_DRAIN->D_SPIN->DONE.
REQ-019 Run edge in a run step toggles out_paused; tick in the same cycle uses pre-toggle out_paused.
REQ-020 Lid open in a run step freezes state and out_remain; out_paused unchanged; closing resumes only if out_paused=0.
REQ-021 Actuators active only in run step with out_paused=0 and in_openBtn=0: FILL inValve; AGIT motor; DRAIN outValve; SPIN outValve+motor+spin; else all 0, combinational from registered state and in_openBtn.
REQ-022 DONE: out_done=1, out_remain=0, actuators 0; run edge -> IDLE. out_remain=0 in IDLE.
REQ-023 Mode/water changes after start SHALL have no effect until next IDLE start.

Reset
REQ-024 in_resetBtn=0 immediately forces IDLE, out_remain 0, out_paused 0, out_done 0, out_beep 0, actuators 0, prev 0, latched mode/water 0, beep counter 0, regardless of clock or mid-step.
REQ-025 Release SHALL need no tick or run edge; first start requires a fresh run edge.

Configuration
REQ-026 Macro DONE_BEEP_EN defined: entering DONE sets out_beep=1 for BEEP_T counted ticks (ticks counted regardless of lid), cleared early by run edge or reset.
REQ-027 Macro DONE_BEEP_EN undefined: out_beep tied 0, no beep counter logic.

Verification
REQ-028 mode=100, water=0, run edge -> W_FILL remain 2, W_AGIT remain 10 after 2 ticks, W_DRAIN remain 3 after 12, DONE/out_done=1 after 15 ticks.
REQ-029 mode=001, run edge -> D_DRAIN 3 ticks outValve=1, D_SPIN 4 ticks spin=motor=outValve=1, DONE after 7 ticks.
REQ-030 mode=110, water=3: at W_AGIT remain 7, lid open, 5 ticks -> state 2, remain 7, actuators 0; lid close -> motor=1, DONE after 8+10+3+8+6+3+4=42 total counted ticks.
REQ-031 mode=000 or lid open at run edge -> stays IDLE; run edge in R_AGIT -> paused, 4 ticks no change; second edge resumes.
REQ-032 in_resetBtn=0 mid R_SPIN -> state 0, all outputs 0 same cycle, no clock edge needed.
REQ-033 DONE_BEEP_EN: beep high exactly 5 ticks after DONE then 0; without macro beep stays 0; run edge in DONE -> IDLE.
